// File: rtl/z_analyser_pkg.sv
//------------------------------------------------------------------------------
// Module : z_analyser_pkg
// Brief  : Shared state type and saturating-increment helper for z_pulse_analyser.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package z_analyser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  // Returns value+1, or value unchanged once it has reached 2^width-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [32:0] w_max;
    w_max = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= w_max) begin
      return value;
    end
    return value + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Saturating up-counter; clr together with inc loads 1.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter
  import z_analyser_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= i_inc ? W'(1) : '0;
    end else if (i_inc) begin
      r_q <= W'(sat_inc(32'(r_q), W));
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/z_pulse_analyser.sv
//------------------------------------------------------------------------------
// Module : z_pulse_analyser
// Brief  : Measures high pulses on z, counts valid pulses and glitches, and
//          reports each valid pulse length through a one-entry buffer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module z_pulse_analyser
  import z_analyser_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 8,
  parameter int MIN_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic             clr,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [LEN_W-1:0] last_len,
  output logic             z_level,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [LEN_W-1:0] rpt_len,
  output logic             ovf
);

  localparam logic [LEN_W-1:0] C_MIN_LEN = LEN_W'(MIN_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_z_q;
  logic [LEN_W-1:0] w_len;
  logic             w_len_clr;
  logic             w_len_inc;
  logic             w_end;
  logic             w_end_valid;
  logic             w_end_glitch;
  logic             w_load;
  logic [LEN_W-1:0] r_last_len;
  logic             r_rpt_valid;
  logic [LEN_W-1:0] r_rpt_len;
  logic             r_ovf;

  // z_q resets high so a pulse already in progress at reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_z_q   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_z_q   <= z;
    end
  end

  // len is held at zero outside a pulse; a rise loads 1 via clr+inc.
  always_comb begin
    w_state_nxt = r_state;
    w_len_clr   = 1'b1;
    w_len_inc   = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        if (z && !r_z_q) begin
          w_state_nxt = HIGH;
          w_len_inc   = 1'b1;
        end
      end
      HIGH: begin
        if (z) begin
          w_len_clr = 1'b0;
          w_len_inc = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_end       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_end_valid  = w_end && (w_len >= C_MIN_LEN);
  assign w_end_glitch = w_end && (w_len < C_MIN_LEN);
  assign w_load       = w_end_valid && (!r_rpt_valid || rpt_ready);

  sat_counter #(.W(LEN_W)) u_len_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_len_clr),
    .i_inc (w_len_inc),
    .o_q   (w_len)
  );

  // Gating inc with clr makes the clear win over a simultaneous pulse end.
  sat_counter #(.W(CNT_W)) u_pulse_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_inc (w_end_valid && !clr),
    .o_q   (pulse_cnt)
  );

  sat_counter #(.W(CNT_W)) u_glitch_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_inc (w_end_glitch && !clr),
    .o_q   (glitch_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_len <= '0;
      r_ovf      <= 1'b0;
    end else if (clr) begin
      r_last_len <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_end_valid) begin
        r_last_len <= w_len;
      end
      if (w_end_valid && !w_load) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // A new load takes priority over the handshake that would empty the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_valid <= 1'b0;
      r_rpt_len   <= '0;
    end else if (w_load) begin
      r_rpt_valid <= 1'b1;
      r_rpt_len   <= w_len;
    end else if (r_rpt_valid && rpt_ready) begin
      r_rpt_valid <= 1'b0;
    end
  end

  assign last_len  = r_last_len;
  assign z_level   = r_z_q;
  assign rpt_valid = r_rpt_valid;
  assign rpt_len   = r_rpt_len;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
